// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with dp, blink, leading-zero suppression and blank gap.
// Latency: seg_out/an_out are registered one cycle after the (cnt, idx) scan state.
// Backpressure: none; free-running scan, and data_in is sampled once per frame.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzs_en,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      dp_lat;
  logic [NUM_DIGITS-1:0]      blink_lat;
  logic                       lzs_lat;
  logic [BW-1:0]              blink_cnt;
  logic                       blink_on;

  logic                       frame_load;
  logic                       slot_end;
  logic                       frame_end;
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic                       lz_run;
  logic [3:0]                 cur_code;
  logic                       cur_blank;
  logic [7:0]                 seg_nxt;
  logic [NUM_DIGITS-1:0]      an_nxt;

  assign frame_load = (cnt == '0) && (idx == '0);
  assign slot_end   = (cnt == CNT_MAX);
  assign frame_end  = slot_end && (idx == IDX_MAX);

  // Segment pattern {a,b,c,d,e,f,g,dp} for one digit code; unknown codes are blank.
  function automatic logic [7:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 8'hFC;
      4'h1:    decode = 8'h60;
      4'h2:    decode = 8'hDA;
      4'h3:    decode = 8'hF2;
      4'h4:    decode = 8'h66;
      4'h5:    decode = 8'hB6;
      4'h6:    decode = 8'hBE;
      4'h7:    decode = 8'hE0;
      4'h8:    decode = 8'hFE;
      4'h9:    decode = 8'hF6;
      4'hC:    decode = 8'h02;
      default: decode = 8'h00;
    endcase
  endfunction

  // Slot timer and digit index; idx advances when the slot timer wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame latch: snapshot digits and masks at the start of digit 0's slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '1;
      dp_lat    <= '0;
      blink_lat <= '0;
      lzs_lat   <= 1'b0;
    end else if (frame_load) begin
      shadow    <= data_in;
      dp_lat    <= dp_mask;
      blink_lat <= blink_mask;
      lzs_lat   <= lzs_en;
    end
  end

  // Blink phase: toggles every BLINK_DIV completed frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Leading-zero map: digit i>0 is blank while it and every higher digit are 0 or F.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run & ((shadow[i] == 4'h0) || (shadow[i] == 4'hF));
      lz_blank[i] = lz_run & lzs_lat;
    end
  end

  // Next segment/anode values; the blank gap keeps decode off the shadow load cycle.
  always_comb begin
    cur_code  = shadow[idx];
    cur_blank = (blink_lat[idx] & ~blink_on) | lz_blank[idx];
    seg_nxt   = 8'h00;
    an_nxt    = '0;
    if (cnt >= CNT_BLANK) begin
      an_nxt = NUM_DIGITS'(1) << idx;
      if (!cur_blank) begin
        seg_nxt = decode(cur_code) | {7'b0, dp_lat[idx]};
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out     <= 8'h00;
      an_out      <= '0;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_nxt;
      an_out      <= an_nxt;
      frame_start <= frame_load;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_DIV=2.
// Each cycle compares {frame_start, an_out, seg_out} against hand-built digit tables.
// Cycle k after reset release shows scan state s=k-1: cnt=s%4, idx=(s/4)%4.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        lzs_en;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_start;

  int n_cmp;
  int n_err;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1),
    .BLINK_DIV   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .lzs_en     (lzs_en),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; outputs hold reset values afterwards.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v;
    data_in = 16'h1234; dp_mask = 4'hF; blink_mask = 4'h0; lzs_en = 1'b0;
    rst = 1'b1;
    exp_v = 13'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({frame_start, an_out, seg_out} !== exp_v) begin
        n_err++;
        $display("FAIL reset k=%0d got fs/an/seg=%b/%b/%h want 0/0000/00", k, frame_start, an_out, seg_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [7:0]  tab [4];
    logic [12:0] exp_v;
    int s, c, d;
    tab = '{8'h66, 8'hF2, 8'hDA, 8'h60};
    data_in = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0; lzs_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      s = k - 1; c = s % 4; d = (s / 4) % 4;
      tick();
      exp_v = {(s % 16 == 0), (c == 0) ? 4'b0000 : 4'(1 << d), (c == 0) ? 8'h00 : tab[d]};
      n_cmp++;
      if ({frame_start, an_out, seg_out} !== exp_v) begin
        n_err++;
        $display("FAIL scan k=%0d got fs/an/seg=%b/%b/%h want %b/%b/%h", k,
                 frame_start, an_out, seg_out, exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_midframe_update();
    logic [7:0]  tab0 [4];
    logic [7:0]  tab1 [4];
    logic [7:0]  eseg;
    logic [12:0] exp_v;
    int s, c, d;
    tab0 = '{8'h66, 8'hF2, 8'hDA, 8'h60};
    tab1 = '{8'hFE, 8'hE0, 8'hBE, 8'hB6};
    data_in = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0; lzs_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      s = k - 1; c = s % 4; d = (s / 4) % 4;
      if (k == 6) data_in = 16'h5678;
      tick();
      eseg = (s < 16) ? tab0[d] : tab1[d];
      exp_v = {(s % 16 == 0), (c == 0) ? 4'b0000 : 4'(1 << d), (c == 0) ? 8'h00 : eseg};
      n_cmp++;
      if ({frame_start, an_out, seg_out} !== exp_v) begin
        n_err++;
        $display("FAIL midframe k=%0d got fs/an/seg=%b/%b/%h want %b/%b/%h", k,
                 frame_start, an_out, seg_out, exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_lzs();
    logic [15:0] vec [2];
    logic [7:0]  tab [2][4];
    logic [12:0] exp_v;
    int s, c, d;
    vec = '{16'h00C0, 16'h0000};
    tab = '{'{8'hFC, 8'h02, 8'h00, 8'h00}, '{8'hFC, 8'h00, 8'h00, 8'h00}};
    for (int v = 0; v < 2; v++) begin
      data_in = vec[v]; dp_mask = 4'h0; blink_mask = 4'h0; lzs_en = 1'b1;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
        s = k - 1; c = s % 4; d = (s / 4) % 4;
        tick();
        exp_v = {(s == 0), (c == 0) ? 4'b0000 : 4'(1 << d), (c == 0) ? 8'h00 : tab[v][d]};
        n_cmp++;
        if ({frame_start, an_out, seg_out} !== exp_v) begin
          n_err++;
          $display("FAIL lzs v=%0d k=%0d got fs/an/seg=%b/%b/%h want %b/%b/%h", v, k,
                   frame_start, an_out, seg_out, exp_v[12], exp_v[11:8], exp_v[7:0]);
        end
      end
    end
    lzs_en = 1'b0;
  endtask

  task automatic test_blink();
    logic [7:0]  eseg;
    logic [12:0] exp_v;
    int s, c, d, f;
    data_in = 16'h0009; dp_mask = 4'h0; blink_mask = 4'b0001; lzs_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      s = k - 1; c = s % 4; d = (s / 4) % 4; f = s / 16;
      tick();
      if (d == 0) eseg = (f == 2 || f == 3) ? 8'h00 : 8'hF6;
      else        eseg = 8'hFC;
      exp_v = {(s % 16 == 0), (c == 0) ? 4'b0000 : 4'(1 << d), (c == 0) ? 8'h00 : eseg};
      n_cmp++;
      if ({frame_start, an_out, seg_out} !== exp_v) begin
        n_err++;
        $display("FAIL blink k=%0d frame=%0d got fs/an/seg=%b/%b/%h want %b/%b/%h", k, f,
                 frame_start, an_out, seg_out, exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
    blink_mask = 4'h0;
  endtask

  task automatic test_dp();
    logic [7:0]  tab [4];
    logic [12:0] exp_v;
    int s, c, d;
    tab = '{8'h00, 8'hFE, 8'hFF, 8'hFE};
    data_in = 16'h888F; dp_mask = 4'b0100; blink_mask = 4'h0; lzs_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      s = k - 1; c = s % 4; d = (s / 4) % 4;
      tick();
      exp_v = {(s == 0), (c == 0) ? 4'b0000 : 4'(1 << d), (c == 0) ? 8'h00 : tab[d]};
      n_cmp++;
      if ({frame_start, an_out, seg_out} !== exp_v) begin
        n_err++;
        $display("FAIL dp k=%0d got fs/an/seg=%b/%b/%h want %b/%b/%h", k,
                 frame_start, an_out, seg_out, exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
    dp_mask = 4'h0;
  endtask

  task automatic test_reset_midscan();
    data_in = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0; lzs_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) tick();
    n_cmp++;
    if ({frame_start, an_out, seg_out} !== {1'b0, 4'b0100, 8'hDA}) begin
      n_err++;
      $display("FAIL midrst_pre got fs/an/seg=%b/%b/%h want 0/0100/da", frame_start, an_out, seg_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({frame_start, an_out, seg_out} !== 13'h0) begin
      n_err++;
      $display("FAIL midrst_hit got fs/an/seg=%b/%b/%h want 0/0000/00", frame_start, an_out, seg_out);
    end
    tick();
    n_cmp++;
    if ({frame_start, an_out, seg_out} !== {1'b1, 4'b0000, 8'h00}) begin
      n_err++;
      $display("FAIL midrst_frame got fs/an/seg=%b/%b/%h want 1/0000/00", frame_start, an_out, seg_out);
    end
    tick();
    n_cmp++;
    if ({frame_start, an_out, seg_out} !== {1'b0, 4'b0001, 8'h66}) begin
      n_err++;
      $display("FAIL midrst_digit0 got fs/an/seg=%b/%b/%h want 0/0001/66", frame_start, an_out, seg_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    data_in = 16'hFFFF; dp_mask = 4'h0; blink_mask = 4'h0; lzs_en = 1'b0;
    test_reset();
    test_scan();
    test_midframe_update();
    test_lzs();
    test_blink();
    test_dp();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
